lfsr_galois_checker: RTL and testbench

- PRBS checker that sits directly downstream of the Galois LFSR generator and consumes its output words.
- Self-synchronises by seeding from received data, then flywheels its own Galois next-state prediction.
- Compares each received word against the prediction and reports lock status, error pulses and a saturating error count.
- Used on loopback and link tests: the generator drives the link, and this block checks the far end.

---
 rtl/lfsr_galois_checker.sv | 186 ++++++++++++++++++
 tb/tb_lfsr_galois_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_galois_checker.sv
// lfsr_galois_checker: self-synchronising PRBS checker for the Galois LFSR generator.
// Seeds its prediction from received data while hunting, then flywheels once locked.
// Optional macro LFSR_CHK_BITERR_EN adds bit_err_count (saturating mismatched-bit total).
module lfsr_galois_checker #(
   parameter int unsigned       WIDTH     = 16,
   parameter logic [WIDTH-1:0]  TAPS      = 16'hB400,
   parameter int unsigned       LOCK_CNT  = 4,
   parameter int unsigned       LOSS_CNT  = 4,
   parameter int unsigned       ERR_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  locked,
   output logic                  err_pulse,
   output logic [ERR_CNT_W-1:0]  err_count
`ifdef LFSR_CHK_BITERR_EN
  ,output logic [ERR_CNT_W-1:0]  bit_err_count
`endif
);

   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);

   localparam logic [0:0] S_HUNT   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   // Galois next-state: shift right, fold bit 0 back into the tapped positions and the MSB.
   function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < int'(WIDTH) - 1; i++) begin
         n[i] = s[i+1] ^ (TAPS[i] & s[0]);
      end
      n[WIDTH-1] = s[0];
      return n;
   endfunction

   logic [0:0]           r_state;
   logic [WIDTH-1:0]     r_pred;
   logic                 r_primed;
   logic [GOOD_W-1:0]    r_good_cnt;
   logic [BAD_W-1:0]     r_bad_cnt;
   logic                 r_locked;
   logic                 r_err_pulse;
   logic [ERR_CNT_W-1:0] r_err_count;

   logic [0:0]           w_state_nxt;
   logic [WIDTH-1:0]     w_pred_nxt;
   logic                 w_primed_nxt;
   logic [GOOD_W-1:0]    w_good_nxt;
   logic [BAD_W-1:0]     w_bad_nxt;
   logic                 w_pulse_nxt;
   logic [ERR_CNT_W-1:0] w_err_count_nxt;
   logic                 w_mismatch;

   // State register plus all registered outputs.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state     <= S_HUNT;
         r_pred      <= '0;
         r_primed    <= 1'b0;
         r_good_cnt  <= '0;
         r_bad_cnt   <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pred      <= w_pred_nxt;
         r_primed    <= w_primed_nxt;
         r_good_cnt  <= w_good_nxt;
         r_bad_cnt   <= w_bad_nxt;
         r_locked    <= (w_state_nxt == S_LOCKED);
         r_err_pulse <= w_pulse_nxt;
         r_err_count <= w_err_count_nxt;
      end
   end

   // Hunt/lock decisions, prediction update and error counting for each valid beat.
   always_comb begin
      w_state_nxt  = r_state;
      w_pred_nxt   = r_pred;
      w_primed_nxt = r_primed;
      w_good_nxt   = r_good_cnt;
      w_bad_nxt    = r_bad_cnt;
      w_pulse_nxt  = 1'b0;
      w_mismatch   = 1'b0;

      if (in_valid) begin
         case (r_state)
            S_HUNT: begin
               if (in_data == '0) begin
                  // The all-zero lock-up word can never seed the predictor.
                  w_primed_nxt = 1'b0;
                  w_good_nxt   = '0;
               end else begin
                  if (r_primed && (in_data == r_pred)) begin
                     w_good_nxt = r_good_cnt + GOOD_W'(1);
                     if (r_good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                        w_state_nxt = S_LOCKED;
                        w_bad_nxt   = '0;
                     end
                  end else begin
                     w_good_nxt = '0;
                  end
                  w_pred_nxt   = f_next(in_data);
                  w_primed_nxt = 1'b1;
               end
            end
            S_LOCKED: begin
               w_pred_nxt = f_next(r_pred);
               if (in_data != r_pred) begin
                  w_mismatch  = 1'b1;
                  w_pulse_nxt = 1'b1;
                  w_bad_nxt   = r_bad_cnt + BAD_W'(1);
                  if (r_bad_cnt == BAD_W'(LOSS_CNT - 1)) begin
                     w_state_nxt  = S_HUNT;
                     w_primed_nxt = 1'b0;
                     w_good_nxt   = '0;
                  end
               end else begin
                  w_bad_nxt = '0;
               end
            end
            default: begin
               w_state_nxt = S_HUNT;
            end
         endcase
      end

      // Clear overrides a simultaneous increment; the count sticks at all-ones.
      if (clear) begin
         w_err_count_nxt = '0;
      end else if (w_mismatch && (r_err_count != '1)) begin
         w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
      end else begin
         w_err_count_nxt = r_err_count;
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;

`ifdef LFSR_CHK_BITERR_EN
   localparam int unsigned PC_W  = $clog2(WIDTH + 1);
   localparam int unsigned SUM_W = ((ERR_CNT_W > PC_W) ? ERR_CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] BIT_MAX = SUM_W'((64'd1 << ERR_CNT_W) - 64'd1);

   logic [ERR_CNT_W-1:0] r_bit_err_count;
   logic [PC_W-1:0]      w_popcnt;
   logic [SUM_W-1:0]     w_bit_sum;
   logic [ERR_CNT_W-1:0] w_bit_nxt;

   // Number of differing bits on this beat, saturated into the running total.
   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_popcnt = w_popcnt + PC_W'(in_data[i] ^ r_pred[i]);
      end
      w_bit_sum = SUM_W'(r_bit_err_count) + SUM_W'(w_popcnt);
      if (clear) begin
         w_bit_nxt = '0;
      end else if (w_mismatch) begin
         w_bit_nxt = (w_bit_sum > BIT_MAX) ? '1 : ERR_CNT_W'(w_bit_sum);
      end else begin
         w_bit_nxt = r_bit_err_count;
      end
   end

   // Bit-error total register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_bit_err_count <= '0;
      end else begin
         r_bit_err_count <= w_bit_nxt;
      end
   end

   assign bit_err_count = r_bit_err_count;
`endif

endmodule

// File: tb/tb_lfsr_galois_checker.sv
// Scoreboard bench for lfsr_galois_checker: default instance plus a 2-bit-counter instance.
module tb_lfsr_galois_checker;

   localparam int unsigned  WIDTH    = 16;
   localparam logic [15:0]  TAPS     = 16'hB400;
   localparam int           LOCK_CNT = 4;
   localparam int           LOSS_CNT = 4;
   localparam int           MAX16    = 65535;
   localparam int           MAX2     = 3;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'h0;

   logic        locked_a, pulse_a, locked_b, pulse_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;
`ifdef LFSR_CHK_BITERR_EN
   logic [15:0] bcnt_a;
   logic [1:0]  bcnt_b;
`endif

   lfsr_galois_checker u_dut_a (
      .clk(clk), .rst_b(rst_b), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a)
`ifdef LFSR_CHK_BITERR_EN
     ,.bit_err_count(bcnt_a)
`endif
   );

   lfsr_galois_checker #(.ERR_CNT_W(2)) u_dut_b (
      .clk(clk), .rst_b(rst_b), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b)
`ifdef LFSR_CHK_BITERR_EN
     ,.bit_err_count(bcnt_b)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int lk; int pl; int cnt; int cnt2; int bc; int bc2;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   // Reference model state (spec-level view, plain arithmetic).
   int          m_locked, m_primed, m_good, m_bad, m_pulse;
   int          m_cnt, m_cnt2, m_bc, m_bc2;
   logic [15:0] m_pred;
   logic [15:0] g;

   function automatic logic [15:0] gal_next(input logic [15:0] s);
      logic [15:0] fb;
      fb = (TAPS & 16'h7FFF) | 16'h8000;
      return (s >> 1) ^ (s[0] ? fb : 16'h0000);
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_primed = 0; m_good = 0; m_bad = 0; m_pulse = 0;
      m_cnt = 0; m_cnt2 = 0; m_bc = 0; m_bc2 = 0; m_pred = 16'h0;
   endtask

   task automatic model_step(input bit v, input logic [15:0] d, input bit clr);
      int pc;
      m_pulse = 0;
      if (v) begin
         if (m_locked == 0) begin
            if (d == 16'h0) begin
               m_primed = 0; m_good = 0;
            end else begin
               if (m_primed == 1 && d == m_pred) begin
                  m_good = m_good + 1;
                  if (m_good == LOCK_CNT) begin m_locked = 1; m_bad = 0; end
               end else begin
                  m_good = 0;
               end
               m_pred = gal_next(d);
               m_primed = 1;
            end
         end else begin
            if (d != m_pred) begin
               pc = $countones(d ^ m_pred);
               m_pulse = 1;
               m_cnt  = sat(m_cnt + 1, MAX16);
               m_cnt2 = sat(m_cnt2 + 1, MAX2);
               m_bc   = sat(m_bc + pc, MAX16);
               m_bc2  = sat(m_bc2 + pc, MAX2);
               m_bad  = m_bad + 1;
               if (m_bad == LOSS_CNT) begin m_locked = 0; m_primed = 0; m_good = 0; end
            end else begin
               m_bad = 0;
            end
            m_pred = gal_next(m_pred);
         end
      end
      if (clr) begin
         m_cnt = 0; m_cnt2 = 0; m_bc = 0; m_bc2 = 0;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle at the falling edge and queue what the outputs must show after the next rise.
   task automatic beat(input bit v, input logic [15:0] d, input bit clr);
      exp_t e;
      @(negedge clk);
      in_valid = v; in_data = d; clear = clr;
      model_step(v, d, clr);
      e.lk = m_locked; e.pl = m_pulse; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.bc = m_bc; e.bc2 = m_bc2;
      q.push_back(e);
   endtask

   task automatic good_beat(input bit clr);
      beat(1'b1, g, clr);
      g = gal_next(g);
   endtask

   task automatic err_beat(input logic [15:0] x, input bit clr);
      beat(1'b1, g ^ x, clr);
      g = gal_next(g);
   endtask

   // Monitor: compare every presented cycle against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_b && q.size() > 0) begin
            e = q.pop_front();
            chk("locked_a", int'(locked_a), e.lk);
            chk("err_pulse_a", int'(pulse_a), e.pl);
            chk("err_count_a", int'(cnt_a), e.cnt);
            chk("locked_b", int'(locked_b), e.lk);
            chk("err_pulse_b", int'(pulse_b), e.pl);
            chk("err_count_b", int'(cnt_b), e.cnt2);
`ifdef LFSR_CHK_BITERR_EN
            chk("bit_err_count_a", int'(bcnt_a), e.bc);
            chk("bit_err_count_b", int'(bcnt_b), e.bc2);
`endif
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   task automatic reset_checks(input string tag);
      chk({tag, "_locked"}, int'(locked_a), 0);
      chk({tag, "_pulse"}, int'(pulse_a), 0);
      chk({tag, "_count"}, int'(cnt_a), 0);
      chk({tag, "_count_b"}, int'(cnt_b), 0);
`ifdef LFSR_CHK_BITERR_EN
      chk({tag, "_bitcount"}, int'(bcnt_a), 0);
`endif
   endtask

   initial begin
      int nv;
      model_reset();
      g = 16'hACE1;
      #1;
      reset_checks("reset");
      @(negedge clk);
      rst_b = 1'b1;

      chk("gen_step1", int'(gal_next(16'hACE1)), int'(16'hE270));
      chk("gen_step2", int'(gal_next(16'hE270)), int'(16'h7138));

      // Acquire lock on the generator sequence.
      beat(1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 8; i++) good_beat(1'b0);

      // Single-bit error while locked.
      err_beat(16'h0001, 1'b0);
      for (int i = 0; i < 3; i++) good_beat(1'b0);

      // Four all-zero beats force relock, then resume.
      for (int i = 0; i < 4; i++) begin beat(1'b1, 16'h0, 1'b0); g = gal_next(g); end
      for (int i = 0; i < 7; i++) good_beat(1'b0);

      // Drop lock again, then reacquire through random idle gaps.
      for (int i = 0; i < 4; i++) begin beat(1'b1, 16'h0, 1'b0); g = gal_next(g); end
      nv = 0;
      while (nv < 20) begin
         if ($urandom_range(1, 0) == 1) begin good_beat(1'b0); nv++; end
         else beat(1'b0, 16'($urandom), 1'b0);
      end

      // Six spaced errors saturate the 2-bit counter; a seventh coincides with clear.
      for (int i = 0; i < 6; i++) begin
         err_beat(16'h0001, 1'b0);
         good_beat(1'b0);
         beat(1'b0, 16'h0, 1'b0);
      end
      err_beat(16'h0001, 1'b1);
      good_beat(1'b0);

      // Two-bit error word.
      err_beat(16'h0300, 1'b0);
      good_beat(1'b0);

      // Reach err_count=2 while locked, then reset asynchronously.
      good_beat(1'b1);
      err_beat(16'h8000, 1'b0);
      good_beat(1'b0);
      err_beat(16'h0010, 1'b0);
      good_beat(1'b0);
      @(negedge clk);
      rst_b = 1'b0; in_valid = 1'b0; clear = 1'b0;
      #1;
      reset_checks("midreset");
      model_reset();
      #2;
      rst_b = 1'b1;

      // Randomised mix of gaps, corruptions, zero words and clears.
      g = 16'($urandom) | 16'h0001;
      for (int i = 0; i < 400; i++) begin
         int r;
         bit c;
         r = int'($urandom_range(99, 0));
         c = ($urandom_range(99, 0) < 3);
         if (r < 35) beat(1'b0, 16'($urandom), c);
         else if (r < 42) err_beat(16'($urandom) | 16'h0004, c);
         else if (r < 45) begin beat(1'b1, 16'h0, c); g = gal_next(g); end
         else good_beat(c);
      end

      beat(1'b0, 16'h0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
